// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: position counters, sync pulses, visible-area flag
// and one-cycle line/frame start strobes, all registered.
module vga_timing_gen #(
    parameter int unsigned H_DISP    = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_DISP    = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          HS_ACTIVE = 1'b0,
    parameter bit          VS_ACTIVE = 1'b0,
    parameter int unsigned CW        = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [CW-1:0] h_cnt,
    output logic [CW-1:0] v_cnt,
    output logic          hsync,
    output logic          vsync,
    output logic          valid,
    output logic          line_tick,
    output logic          frame_tick
);

    localparam int unsigned H_TOTAL  = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_DISP + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_DISP + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    // The last position on each axis must be representable in CW bits.
    if (((H_TOTAL - 1) >> CW) != 0 || ((V_TOTAL - 1) >> CW) != 0) begin : g_cw_check
        $error("vga_timing_gen: CW too narrow for H_TOTAL-1 / V_TOTAL-1");
    end

    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          valid_q, valid_d;
    logic          line_q, line_d;
    logic          frame_q, frame_d;
    logic          h_wrap;
    logic          v_wrap;

    assign h_wrap = (h_q == H_LAST);
    assign v_wrap = (v_q == V_LAST);

    // Next position plus a decode of that position, so flags line up with the counters.
    always_comb begin
        h_d     = h_q;
        v_d     = v_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        valid_d = valid_q;
        line_d  = 1'b0;
        frame_d = 1'b0;
        if (en) begin
            h_d = h_wrap ? '0 : h_q + CW'(1);
            if (h_wrap) begin
                v_d = v_wrap ? '0 : v_q + CW'(1);
            end
            valid_d = (32'(h_d) < H_DISP) && (32'(v_d) < V_DISP);
            hsync_d = ((32'(h_d) >= HS_START) && (32'(h_d) < HS_END)) ? HS_ACTIVE : ~HS_ACTIVE;
            vsync_d = ((32'(v_d) >= VS_START) && (32'(v_d) < VS_END)) ? VS_ACTIVE : ~VS_ACTIVE;
            line_d  = h_wrap;
            frame_d = h_wrap && v_wrap;
        end
    end

    // Reset parks on the last pixel of a frame so the first enabled edge lands on (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q     <= H_LAST;
            v_q     <= V_LAST;
            hsync_q <= ~HS_ACTIVE;
            vsync_q <= ~VS_ACTIVE;
            valid_q <= 1'b0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            valid_q <= valid_d;
            line_q  <= line_d;
            frame_q <= frame_d;
        end
    end

    assign h_cnt      = h_q;
    assign v_cnt      = v_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign valid      = valid_q;
    assign line_tick  = line_q;
    assign frame_tick = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a reduced raster, checked every clock against a
// linear pixel-index model for both sync polarities.
module tb_vga_timing_gen;

    localparam int unsigned H_DISP = 16, H_FP = 4, H_SYNC = 6, H_BP = 6;
    localparam int unsigned V_DISP = 12, V_FP = 2, V_SYNC = 3, V_BP = 4;
    localparam int unsigned HT     = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int unsigned VT     = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int unsigned FRAME  = HT * VT;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;

    logic [5:0] h0, v0;
    logic       hs0, vs0, va0, lt0, ft0;
    logic [7:0] h1, v1;
    logic       hs1, vs1, va1, lt1, ft1;

    int n_checks = 0;
    int n_errors = 0;

    // Model: linear pixel index within the frame; reset parks on the last pixel.
    int idx    = int'(FRAME) - 1;
    bit exp_lt = 1'b0;
    bit exp_ft = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_DISP(H_DISP), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_DISP(V_DISP), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_ACTIVE(1'b0), .VS_ACTIVE(1'b0), .CW(6)
    ) u_dut_lo (
        .clk(clk), .rst_n(rst_n), .en(en),
        .h_cnt(h0), .v_cnt(v0), .hsync(hs0), .vsync(vs0), .valid(va0),
        .line_tick(lt0), .frame_tick(ft0)
    );

    vga_timing_gen #(
        .H_DISP(H_DISP), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_DISP(V_DISP), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_ACTIVE(1'b1), .VS_ACTIVE(1'b1), .CW(8)
    ) u_dut_hi (
        .clk(clk), .rst_n(rst_n), .en(en),
        .h_cnt(h1), .v_cnt(v1), .hsync(hs1), .vsync(vs1), .valid(va1),
        .line_tick(lt1), .frame_tick(ft1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        idx    = int'(FRAME) - 1;
        exp_lt = 1'b0;
        exp_ft = 1'b0;
    endtask

    task automatic model_step(input bit en_v);
        if (en_v) begin
            idx    = (idx + 1) % int'(FRAME);
            exp_lt = ((idx % int'(HT)) == 0);
            exp_ft = (idx == 0);
        end else begin
            exp_lt = 1'b0;
            exp_ft = 1'b0;
        end
    endtask

    task automatic check_all();
        int eh;
        int ev;
        bit in_hs;
        bit in_vs;
        bit vis;
        eh    = idx % int'(HT);
        ev    = idx / int'(HT);
        in_hs = (eh >= int'(H_DISP + H_FP)) && (eh < int'(H_DISP + H_FP + H_SYNC));
        in_vs = (ev >= int'(V_DISP + V_FP)) && (ev < int'(V_DISP + V_FP + V_SYNC));
        vis   = (eh < int'(H_DISP)) && (ev < int'(V_DISP));
        check("h_lo",     32'(h0),  32'(eh));
        check("v_lo",     32'(v0),  32'(ev));
        check("hsync_lo", 32'(hs0), 32'(!in_hs));
        check("vsync_lo", 32'(vs0), 32'(!in_vs));
        check("valid_lo", 32'(va0), 32'(vis));
        check("ltick_lo", 32'(lt0), 32'(exp_lt));
        check("ftick_lo", 32'(ft0), 32'(exp_ft));
        check("h_hi",     32'(h1),  32'(eh));
        check("v_hi",     32'(v1),  32'(ev));
        check("hsync_hi", 32'(hs1), 32'(in_hs));
        check("vsync_hi", 32'(vs1), 32'(in_vs));
        check("valid_hi", 32'(va1), 32'(vis));
        check("ltick_hi", 32'(lt1), 32'(exp_lt));
        check("ftick_hi", 32'(ft1), 32'(exp_ft));
    endtask

    // Drive en for the coming edge, then sample 1ns after it.
    task automatic cycle(input bit en_v);
        en = en_v;
        @(posedge clk);
        #1;
        if (rst_n) model_step(en_v);
        else       model_reset();
        check_all();
    endtask

    initial begin
        int ft_seen;
        int first_ft;
        int period;
        int hs_cnt;
        int vs_cnt;
        int va_cnt;
        int run;
        int max_run;
        bit found;

        // Reset state
        for (int i = 0; i < 3; i++) cycle(1'b0);
        rst_n = 1'b1;

        // Free run for two frames
        ft_seen = 0; first_ft = -1; period = -1;
        hs_cnt = 0; vs_cnt = 0; va_cnt = 0;
        for (int i = 0; i < int'(2 * FRAME) + 8; i++) begin
            cycle(1'b1);
            if (i == 0) begin
                check("first_h",     32'(h0),  32'd0);
                check("first_v",     32'(v0),  32'd0);
                check("first_valid", 32'(va0), 32'd1);
                check("first_ltick", 32'(lt0), 32'd1);
                check("first_ftick", 32'(ft0), 32'd1);
            end
            if (i == 1) begin
                check("second_h",     32'(h0),  32'd1);
                check("second_ltick", 32'(lt0), 32'd0);
                check("second_ftick", 32'(ft0), 32'd0);
            end
            if (ft0) begin
                if (ft_seen == 0) first_ft = i;
                if (ft_seen == 1) period = i - first_ft;
                ft_seen++;
            end
            if (ft_seen == 1) begin
                if (!hs0) hs_cnt++;
                if (!vs0) vs_cnt++;
                if (va0)  va_cnt++;
            end
        end
        check("frame_period_edges", 32'(period), 32'(FRAME));
        check("hsync_active_cycles", 32'(hs_cnt), 32'(H_SYNC * VT));
        check("vsync_active_cycles", 32'(vs_cnt), 32'(V_SYNC * HT));
        check("valid_cycles",        32'(va_cnt), 32'(H_DISP * V_DISP));

        // en once every 4 clocks
        ft_seen = 0; first_ft = -1; period = -1; run = 0; max_run = 0;
        for (int i = 0; i < int'(8 * FRAME) + 16; i++) begin
            cycle((i % 4) == 0);
            if (lt0) begin
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (ft0) begin
                if (ft_seen == 0) first_ft = i;
                if (ft_seen == 1) period = i - first_ft;
                ft_seen++;
            end
        end
        check("frame_period_clocks", 32'(period), 32'(4 * FRAME));
        check("ltick_width", 32'(max_run), 32'd1);

        // Random enable
        for (int i = 0; i < 2000; i++) cycle(($urandom % 3) != 0);

        // Reset mid-frame inside an hsync pulse
        found = 1'b0;
        for (int i = 0; i < int'(FRAME) + 4 && !found; i++) begin
            if (idx == 8 * int'(HT) + 20) found = 1'b1;
            else cycle(1'b1);
        end
        check("reached_mid_frame", 32'(found), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        for (int i = 0; i < 3; i++) cycle(1'b1);
        rst_n = 1'b1;
        cycle(1'b1);
        check("restart_h",     32'(h0),  32'd0);
        check("restart_v",     32'(v0),  32'd0);
        check("restart_ftick", 32'(ft0), 32'd1);
        for (int i = 0; i < 100; i++) cycle(1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
